// File: rtl/psg_mixer_pkg.sv
// psg_mixer_pkg: shared types, widths and helpers for the PSG audio mixer.
//   state_t : sequencer states (IDLE, MAC_A, MAC_B, MAC_C, FILT, OUT)
//   ACC_W   : accumulator width (holds 3 x 4064 = 12192)
//   SND_W   : output sample width
//   sat16   : clamp an 18-bit signed value to the signed 16-bit range
package psg_mixer_pkg;

  localparam int ACC_W = 14;
  localparam int SND_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MAC_A = 3'd1,
    MAC_B = 3'd2,
    MAC_C = 3'd3,
    FILT  = 3'd4,
    OUT   = 3'd5
  } state_t;

  function automatic logic signed [SND_W-1:0] sat16(input logic signed [17:0] v);
    logic signed [SND_W-1:0] r;
    if (v > 18'sd32767) begin
      r = 16'sh7FFF;
    end else if (v < -18'sd32768) begin
      r = 16'sh8000;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/psg_mixer_dcblock.sv
// psg_dcblock: DC tracker for the mixer output (high-pass by subtraction).
//   CLK, RESET : clock, synchronous active-high reset
//   en         : one-cycle update strobe (asserted in FILT)
//   x          : non-negative 15-bit mix value
//   y          : x minus the tracked DC level (17-bit signed, combinational)
// The tracker is a leaky integrator: dc = dc_acc >>> DC_SHIFT and
// dc_acc accumulates y each update, so dc follows the mean of x with a
// time constant of 2^DC_SHIFT samples.
module psg_dcblock #(
  parameter int DC_SHIFT = 10
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               en,
  input  logic [14:0]        x,
  output logic signed [16:0] y
);

  localparam int DCA_W = 16 + DC_SHIFT;

  logic signed [DCA_W-1:0] dc_acc_r;
  logic signed [15:0]      dc_s;

  // Current DC estimate and the high-passed sample
  always_comb begin
    dc_s = 16'(dc_acc_r >>> DC_SHIFT);
    y    = $signed({2'b00, x}) - $signed({dc_s[15], dc_s});
  end

  // DC accumulator: integrate the residual once per sample
  always_ff @(posedge CLK) begin
    if (RESET) begin
      dc_acc_r <= '0;
    end else if (en) begin
      dc_acc_r <= dc_acc_r + {{(DC_SHIFT - 1){y[16]}}, y};
    end else begin
      dc_acc_r <= dc_acc_r;
    end
  end

endmodule

// File: rtl/psg_mixer.sv
// psg_mixer: scales three PSG channel levels by 4.4 gains through one
// time-shared multiplier, sums them and presents a signed 16-bit sample.
//   CLK, RESET          : clock, synchronous active-high reset
//   CE                  : sample request pulse
//   CHANNEL_A/B/C [7:0] : unsigned channel levels
//   ACTIVE [5:0]        : tone enables [2:0], noise enables [5:3]
//   GAIN_A/B/C [7:0]    : unsigned 4.4 gains (0x10 = 1.0)
//   SND [15:0]          : signed sample, held between strobes
//   SAMPLE              : one-cycle pulse when SND updates (CE + 5 cycles)
//   OVERRUN             : sticky, a CE arrived while busy
// Build option: define PSG_MIXER_DCBLOCK_EN to insert the DC-blocking
// high-pass; otherwise SND = saturate(acc << 1).
module psg_mixer
  import psg_mixer_pkg::*;
#(
  parameter int DC_SHIFT = 10
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CE,
  input  logic [7:0]  CHANNEL_A,
  input  logic [7:0]  CHANNEL_B,
  input  logic [7:0]  CHANNEL_C,
  input  logic [5:0]  ACTIVE,
  input  logic [7:0]  GAIN_A,
  input  logic [7:0]  GAIN_B,
  input  logic [7:0]  GAIN_C,
  output logic [15:0] SND,
  output logic        SAMPLE,
  output logic        OVERRUN
);

  state_t state_r, state_next_s;

  logic [7:0]       chan_a_r, chan_b_r, chan_c_r;
  logic [7:0]       gain_a_r, gain_b_r, gain_c_r;
  logic [5:0]       act_r;
  logic [ACC_W-1:0] acc_r;
  logic [SND_W-1:0] snd_r;
  logic             sample_r;
  logic             overrun_r;

  logic             latch_s;
  logic             mac_s;
  logic             filt_s;
  logic [7:0]       mul_chan_s;
  logic [7:0]       mul_gain_s;
  logic             mul_on_s;
  logic [15:0]      product_s;
  logic [ACC_W-1:0] term_s;
  logic [2:0]       chan_en_s;
  logic [14:0]      x_s;
  logic signed [17:0] y_s;

  assign chan_en_s = act_r[2:0] | act_r[5:3];
  assign product_s = mul_chan_s * mul_gain_s;
  // Drop the 4 fractional gain bits; max 4064 fits easily in ACC_W.
  assign term_s    = mul_on_s ? ACC_W'(product_s >> 4) : {ACC_W{1'b0}};
  assign x_s       = {acc_r, 1'b0};

`ifdef PSG_MIXER_DCBLOCK_EN
  logic signed [16:0] y_dc_s;

  psg_dcblock #(.DC_SHIFT(DC_SHIFT)) u_dcblock (
    .CLK   (CLK),
    .RESET (RESET),
    .en    (filt_s),
    .x     (x_s),
    .y     (y_dc_s)
  );

  assign y_s = {y_dc_s[16], y_dc_s};
`else
  assign y_s = $signed({3'b000, x_s});
`endif

  // Next-state decode and multiplier operand steering
  always_comb begin
    state_next_s = state_r;
    latch_s      = 1'b0;
    mac_s        = 1'b0;
    filt_s       = 1'b0;
    mul_chan_s   = 8'd0;
    mul_gain_s   = 8'd0;
    mul_on_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (CE) begin
          latch_s      = 1'b1;
          state_next_s = MAC_A;
        end else begin
          state_next_s = IDLE;
        end
      end
      MAC_A: begin
        mac_s        = 1'b1;
        mul_chan_s   = chan_a_r;
        mul_gain_s   = gain_a_r;
        mul_on_s     = chan_en_s[0];
        state_next_s = MAC_B;
      end
      MAC_B: begin
        mac_s        = 1'b1;
        mul_chan_s   = chan_b_r;
        mul_gain_s   = gain_b_r;
        mul_on_s     = chan_en_s[1];
        state_next_s = MAC_C;
      end
      MAC_C: begin
        mac_s        = 1'b1;
        mul_chan_s   = chan_c_r;
        mul_gain_s   = gain_c_r;
        mul_on_s     = chan_en_s[2];
        state_next_s = FILT;
      end
      FILT: begin
        filt_s       = 1'b1;
        state_next_s = OUT;
      end
      OUT: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, holding registers, accumulator and registered outputs.
  // SND/SAMPLE load at the FILT->OUT edge so they are visible during OUT.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r   <= IDLE;
      chan_a_r  <= 8'd0;
      chan_b_r  <= 8'd0;
      chan_c_r  <= 8'd0;
      gain_a_r  <= 8'd0;
      gain_b_r  <= 8'd0;
      gain_c_r  <= 8'd0;
      act_r     <= 6'd0;
      acc_r     <= {ACC_W{1'b0}};
      snd_r     <= {SND_W{1'b0}};
      sample_r  <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      sample_r <= filt_s;
      if (latch_s) begin
        chan_a_r <= CHANNEL_A;
        chan_b_r <= CHANNEL_B;
        chan_c_r <= CHANNEL_C;
        gain_a_r <= GAIN_A;
        gain_b_r <= GAIN_B;
        gain_c_r <= GAIN_C;
        act_r    <= ACTIVE;
        acc_r    <= {ACC_W{1'b0}};
      end else if (mac_s) begin
        acc_r <= acc_r + term_s;
      end else begin
        acc_r <= acc_r;
      end
      if (filt_s) begin
        snd_r <= sat16(y_s);
      end else begin
        snd_r <= snd_r;
      end
      if (CE && (state_r != IDLE)) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  assign SND     = snd_r;
  assign SAMPLE  = sample_r;
  assign OVERRUN = overrun_r;

endmodule

// File: tb/tb_psg_mixer.sv
// tb_psg_mixer: directed self-checking bench for psg_mixer.
// Expected mix values are hand-computed (acc << 1); when built with
// PSG_MIXER_DCBLOCK_EN they are passed through a reference DC tracker.
module tb_psg_mixer;

  localparam int DC_SHIFT = 10;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        CE = 1'b0;
  logic [7:0]  CHANNEL_A = 8'd0, CHANNEL_B = 8'd0, CHANNEL_C = 8'd0;
  logic [5:0]  ACTIVE = 6'd0;
  logic [7:0]  GAIN_A = 8'd0, GAIN_B = 8'd0, GAIN_C = 8'd0;
  logic [15:0] SND;
  logic        SAMPLE;
  logic        OVERRUN;

  int          n_checks = 0;
  int          n_errors = 0;
  longint      dc_m = 0;
  logic [15:0] snd_prev = 16'd0;

  psg_mixer #(.DC_SHIFT(DC_SHIFT)) dut (
    .CLK(CLK), .RESET(RESET), .CE(CE),
    .CHANNEL_A(CHANNEL_A), .CHANNEL_B(CHANNEL_B), .CHANNEL_C(CHANNEL_C),
    .ACTIVE(ACTIVE),
    .GAIN_A(GAIN_A), .GAIN_B(GAIN_B), .GAIN_C(GAIN_C),
    .SND(SND), .SAMPLE(SAMPLE), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Expected SND for a given 15-bit mix value x = acc << 1.
  function automatic logic [15:0] exp_snd(input int x);
    longint y;
`ifdef PSG_MIXER_DCBLOCK_EN
    longint dc;
    dc   = dc_m >>> DC_SHIFT;
    y    = x - dc;
    dc_m = dc_m + y;
`else
    y = x;
`endif
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    return 16'(y);
  endfunction

  task automatic do_reset();
    RESET = 1'b1;
    CE    = 1'b0;
    step();
    step();
    RESET    = 1'b0;
    dc_m     = 0;
    snd_prev = 16'd0;
  endtask

  task automatic set_in(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [7:0] ga, input logic [7:0] gb, input logic [7:0] gc,
                        input logic [5:0] act);
    CHANNEL_A = a; CHANNEL_B = b; CHANNEL_C = c;
    GAIN_A = ga; GAIN_B = gb; GAIN_C = gc;
    ACTIVE = act;
  endtask

  // One request in IDLE; checks hold, strobe at +5, strobe width, value.
  task automatic run_sample(input string tag, input int x, input bit scramble);
    logic [15:0] e;
    CE = 1'b1;
    step();
    CE = 1'b0;
    if (scramble) set_in(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 6'h00);
    for (int i = 1; i <= 5; i++) begin
      if (i < 5) begin
        check({tag, "_nostrobe"}, {31'd0, SAMPLE}, 32'd0);
        check({tag, "_hold"}, {16'd0, SND}, {16'd0, snd_prev});
        step();
      end
    end
    e = exp_snd(x);
    check({tag, "_strobe"}, {31'd0, SAMPLE}, 32'd1);
    check({tag, "_snd"}, {16'd0, SND}, {16'd0, e});
    snd_prev = e;
    step();
    check({tag, "_width"}, {31'd0, SAMPLE}, 32'd0);
  endtask

  initial begin
    do_reset();
    check("rst_snd", {16'd0, SND}, 32'd0);
    check("rst_sample", {31'd0, SAMPLE}, 32'd0);
    check("rst_overrun", {31'd0, OVERRUN}, 32'd0);

    // Base case: 3 x 255 = 765, x = 1530 (DC build: 1530 then 1529)
    set_in(8'hFF, 8'hFF, 8'hFF, 8'h10, 8'h10, 8'h10, 6'h3F);
    run_sample("base1", 1530, 1'b0);
    set_in(8'hFF, 8'hFF, 8'hFF, 8'h10, 8'h10, 8'h10, 6'h3F);
    run_sample("base2_scramble", 1530, 1'b1);

    // Channel A noise only: 255 -> 510
    set_in(8'hFF, 8'hFF, 8'hFF, 8'h10, 8'h10, 8'h10, 6'b001000);
    run_sample("mask_a_noise", 510, 1'b0);
    // Nothing enabled
    set_in(8'hFF, 8'hFF, 8'hFF, 8'h10, 8'h10, 8'h10, 6'b000000);
    run_sample("mask_none", 0, 1'b0);

    // Full gain: 65025 >> 4 = 4064, x 3 = 12192, << 1 = 24384
    set_in(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 6'h3F);
    run_sample("full_gain", 24384, 1'b0);

    // Mixed: A 128*32>>4=256, B(noise) 64*8>>4=32, C 17*15>>4=15 -> 303 -> 606
    set_in(8'h80, 8'h40, 8'h11, 8'h20, 8'h08, 8'h0F, 6'b010101);
    run_sample("mixed_trunc", 606, 1'b0);

    // Overrun: CE at 0,2 (dropped),5 (dropped, OUT),6 (accepted)
    do_reset();
    set_in(8'hFF, 8'hFF, 8'hFF, 8'h10, 8'h10, 8'h10, 6'h3F);
    for (int c = 0; c < 13; c++) begin
      int k;
      logic [15:0] e;
      CE = (c == 0 || c == 2 || c == 5 || c == 6) ? 1'b1 : 1'b0;
      step();
      k = c + 1;
      check("ovr_flag", {31'd0, OVERRUN}, (k >= 3) ? 32'd1 : 32'd0);
      if (k == 5 || k == 11) begin
        e = exp_snd(1530);
        check("ovr_strobe", {31'd0, SAMPLE}, 32'd1);
        check("ovr_snd", {16'd0, SND}, {16'd0, e});
        snd_prev = e;
      end else begin
        check("ovr_nostrobe", {31'd0, SAMPLE}, 32'd0);
        check("ovr_hold", {16'd0, SND}, {16'd0, snd_prev});
      end
    end
    CE = 1'b0;

    // Reset mid-operation: CE at 0, RESET at 3 -> aborted, SND/OVERRUN 0 from 4
    set_in(8'hFF, 8'hFF, 8'hFF, 8'h10, 8'h10, 8'h10, 6'h3F);
    CE = 1'b1;
    step();
    CE = 1'b1; // lands in MAC_A, sets OVERRUN so the reset clear is visible
    step();
    CE = 1'b0;
    check("rmid_ovr_set", {31'd0, OVERRUN}, 32'd1);
    step();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    dc_m = 0;
    snd_prev = 16'd0;
    for (int k = 4; k <= 7; k++) begin
      check("rmid_nostrobe", {31'd0, SAMPLE}, 32'd0);
      check("rmid_snd", {16'd0, SND}, 32'd0);
      check("rmid_ovr", {31'd0, OVERRUN}, 32'd0);
      step();
    end
    run_sample("after_reset", 1530, 1'b0);

    // RESET and CE together: CE ignored, no strobe follows
    RESET = 1'b1;
    CE    = 1'b1;
    step();
    RESET = 1'b0;
    CE    = 1'b0;
    dc_m = 0;
    snd_prev = 16'd0;
    for (int k = 1; k <= 7; k++) begin
      check("rst_ce_nostrobe", {31'd0, SAMPLE}, 32'd0);
      check("rst_ce_snd", {16'd0, SND}, 32'd0);
      step();
    end
    set_in(8'h80, 8'h40, 8'h11, 8'h20, 8'h08, 8'h0F, 6'b010101);
    run_sample("post_rst_ce", 606, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/psg_mixer.md
# psg_mixer

Downstream audio stage for the PSG: takes the three 8-bit volume-table outputs (CHANNEL_A/B/C) and the 6-bit ACTIVE mask, and applies a per-channel 4.4 gain. The block sums the channels with one time-shared multiplier. An optional DC-blocking high-pass removes the unipolar offset before the result is presented as a signed 16-bit sample with a one-cycle strobe to the core's audio mixer.

## Interface
Parameters:
- DC_SHIFT, 10: DC-tracker time constant, 2^DC_SHIFT samples; legal range 4..14.

Ports:
- CLK  in  1  system clock; one clock domain.
- RESET  in  1  reset; **one clock; reset is synchronous and active-high.**
- CE  in  1  sample request, one-cycle pulse.
- CHANNEL_A / CHANNEL_B / CHANNEL_C  in  8 each  unsigned PSG channel levels.
- ACTIVE  in  6  tone enables [2:0] and noise enables [5:3] per channel.
- GAIN_A / GAIN_B / GAIN_C  in  8 each  unsigned 4.4 gain; 0x10 = 1.0.
- SND  out  16  signed sample; holds between strobes.
- SAMPLE  out  1  one-cycle pulse when SND updates.
- OVERRUN  out  1  sticky flag: a CE arrived while the block was busy.

## Operation
- States: IDLE, MAC_A, MAC_B, MAC_C, FILT, OUT.
- **IDLE**: on CE, latch CHANNEL_A/B/C, ACTIVE and all three gains into holding registers, clear the 14-bit accumulator, and go to MAC_A.
- **MAC_x**: if channel x is enabled, add (chan × gain) >> 4 to the accumulator; otherwise add 0.
  - Channel i is enabled when ACTIVE[i] | ACTIVE[i+3].
  - Product is 16-bit unsigned; the truncated term is at most 4064; the accumulator is at most 12192.
- **FILT**: form x = acc << 1 (15-bit, non-negative).
  - With DC blocking: dc = dc_acc >>> DC_SHIFT; y = x − dc; dc_acc ← dc_acc + (x − dc). dc_acc is signed, 16+DC_SHIFT bits.
  - Without DC blocking: y = x.
- **OUT**: SND ← saturate(y) to [−32768, 32767]; SAMPLE ← 1; go to IDLE.
- A CE received in any state other than IDLE is dropped and sets OVERRUN. OVERRUN clears only on RESET.
- Input ports are not observed after the latch in IDLE; mid-computation changes have no effect on the sample in progress.

## Timing
- CE high in cycle n while in IDLE produces SAMPLE high in cycle n+5 with SND valid in that same cycle. Latency is fixed at 5 in both configurations.
- Minimum CE spacing is 6 cycles. A CE in cycle n+5 is dropped because the block is in OUT; a CE in cycle n+6 is accepted.
- SAMPLE is exactly one cycle wide. SND changes only in cycles where SAMPLE is high.
- Reset values: SND = 0, SAMPLE = 0, OVERRUN = 0, dc_acc = 0, state IDLE, accumulator = 0.
- RESET mid-operation aborts the sample: no SAMPLE pulse for the aborted request, and SND = 0 from the next cycle.
- If RESET and CE are high together, RESET wins and CE is ignored.

## Configuration
- Macro: PSG_MIXER_DCBLOCK_EN.
- Defined: the DC tracker is instantiated and SND is zero-centred (high-pass).
- Undefined: no dc_acc register and no subtractor. SND = saturate(acc << 1), which is always ≥ 0. The FILT state is kept as a pass-through so latency is unchanged.

## Structure
- Package psg_mixer_pkg holds:
  - the state enum type;
  - ACC_W = 14 and SND_W = 16;
  - a saturate-to-16-bit function.
- Sub-module psg_dcblock contains the dc_acc register, the subtract, and the update. It is instantiated only under PSG_MIXER_DCBLOCK_EN and has a one-cycle enable driven in FILT.

## Test plan
- Base case, macro undefined: all channels = 0xFF, gains = 0x10, ACTIVE = 6'h3F, CE at cycle n → SAMPLE at n+5, SND = 1530.
- Same stimulus with PSG_MIXER_DCBLOCK_EN, DC_SHIFT = 10:
  - first sample SND = 1530; second sample SND = 1529;
  - after 20000 samples, |SND| ≤ 2.
- Masking: ACTIVE = 6'b001000 (channel A noise only), other inputs as in the base case, macro undefined → SND = 510. With ACTIVE = 0 → SND = 0.
- Full gain: all channels = 0xFF, gains = 0xFF, ACTIVE = 6'h3F, macro undefined → SND = 24384. Check there is no wrap in the product or the accumulator.
- Overrun: CE at n and n+2 → a single SAMPLE at n+5 and OVERRUN = 1 from n+3. A CE at n+6 is accepted → SAMPLE at n+11.
- Reset mid-operation: CE at n, RESET at n+3 → no SAMPLE at n+5; SND = 0 and OVERRUN = 0 from n+4. The next CE completes normally.
